// File: rtl/router_pkg.sv
// Shared types and widths for the router ingress queue.
package router_pkg;

  localparam int HDR_W  = 6;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [HDR_W-1:0]  header;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ingress_state_t;

  // Ones-count of a payload word; the router checks the header against this value.
  function automatic logic [HDR_W-1:0] popcount(input logic [DATA_W-1:0] d);
    logic [HDR_W-1:0] c;
    c = {HDR_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      c = c + {{(HDR_W-1){1'b0}}, d[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/router_ingress_fifo.sv
// DEPTH-entry packet FIFO with registered occupancy; head entry is read combinationally.
module router_ingress_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  pkt_t                   wdata,
  output pkt_t                   rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  pkt_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == {LW{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      level  <= {LW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid level
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/router_ingress_queue.sv
// Ingress queue feeding the router FSM with bounded checksum resends and ack timeout.
// Define ROUTER_INGRESS_HDRGEN_EN to generate the header from the payload ones-count.
module router_ingress_queue
  import router_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int RESEND_LIMIT = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [HDR_W-1:0]       src_header,
  input  logic [ADDR_W-1:0]      src_address,
  input  logic [DATA_W-1:0]      src_data,
  input  logic                   cfg_busy,
  input  logic                   rtr_ready,
  input  logic                   rtr_ack_out,
  input  logic                   rtr_bad_packet,
  output logic                   receive,
  output logic [HDR_W-1:0]       header_in,
  output logic [ADDR_W-1:0]      address_in,
  output logic [DATA_W-1:0]      data_in,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            sent_count,
  output logic [15:0]            drop_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(RESEND_LIMIT + 2);

  ingress_state_t state;
  ingress_state_t state_next;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  timer_next;
  logic [AW-1:0]  attempts;
  logic [AW-1:0]  attempts_next;
  logic           pop;
  logic           sent_inc;
  logic           drop_inc;
  logic           full;
  logic           empty;
  pkt_t           push_pkt;
  pkt_t           head;

`ifdef ROUTER_INGRESS_HDRGEN_EN
  logic unused_src_header;
  assign unused_src_header = ^src_header;
  assign push_pkt = '{header: popcount(src_data), address: src_address, data: src_data};
`else
  assign push_pkt = '{header: src_header, address: src_address, data: src_data};
`endif

  assign src_ready = ~full;

  router_ingress_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (src_valid),
    .pop   (pop),
    .wdata (push_pkt),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Sequencer state, ack timer and resend attempt counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= {TW{1'b0}};
      attempts <= {AW{1'b0}};
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      attempts <= attempts_next;
    end
  end

  // Next-state and pop/count decisions
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    attempts_next = attempts;
    pop           = 1'b0;
    sent_inc      = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && rtr_ready && !cfg_busy) begin
          state_next = SEND;
        end else begin
          state_next = IDLE;
        end
      end
      SEND: begin
        // A config cycle aborts the offer; the same head is offered again later
        if (cfg_busy) begin
          state_next = IDLE;
        end else if (!rtr_ready) begin
          state_next = WAIT;
          timer_next = {TW{1'b0}};
        end else begin
          state_next = SEND;
        end
      end
      WAIT: begin
        if (rtr_ack_out) begin
          pop           = 1'b1;
          sent_inc      = 1'b1;
          attempts_next = {AW{1'b0}};
          state_next    = DRAIN;
        end else if (rtr_bad_packet) begin
          if (attempts < AW'(RESEND_LIMIT)) begin
            attempts_next = attempts + AW'(1);
            state_next    = IDLE;
          end else begin
            pop           = 1'b1;
            drop_inc      = 1'b1;
            attempts_next = {AW{1'b0}};
            state_next    = IDLE;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          pop           = 1'b1;
          drop_inc      = 1'b1;
          attempts_next = {AW{1'b0}};
          state_next    = IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      DRAIN: begin
        // bad_packet here reflects a post-ack transmit failure, not a checksum fault
        if (rtr_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered router-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      receive    <= 1'b0;
      header_in  <= {HDR_W{1'b0}};
      address_in <= {ADDR_W{1'b0}};
      data_in    <= {DATA_W{1'b0}};
    end else begin
      receive <= (state_next == SEND);
      if (empty) begin
        header_in  <= {HDR_W{1'b0}};
        address_in <= {ADDR_W{1'b0}};
        data_in    <= {DATA_W{1'b0}};
      end else begin
        header_in  <= head.header;
        address_in <= head.address;
        data_in    <= head.data;
      end
    end
  end

  // Saturating delivery and drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_count <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (sent_inc && (sent_count != 16'hFFFF)) begin
        sent_count <= sent_count + 16'd1;
      end
      if (drop_inc && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/router_ingress_queue.md
Name: router_ingress_queue

Overview:
- Upstream feeder for the router FSM.
- Buffers packets from a source port as {header, address, data} in a FIFO and presents them one at a time on the router's receive/header_in/address_in/data_in.
- Sequences against router ready/ack_out/bad_packet, and resends checksum-rejected packets a bounded number of times before dropping them.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
RESEND_LIMIT, 1, resends allowed after a checksum rejection before the packet is dropped
TIMEOUT, 16, cycles to wait for router ack_out/bad_packet before abandoning the attempt

Ports:
clk  in  1  clock; all logic is on posedge
reset  in  1  synchronous, active-high reset
src_valid  in  1  source packet valid
src_ready  out  1  queue can accept; equals !full
src_header  in  6  source-supplied ones-count; ignored when ROUTER_INGRESS_HDRGEN_EN is defined
src_address  in  12  destination address
src_data  in  32  payload
cfg_busy  in  1  router config_in is active; the queue must not start a send
rtr_ready  in  1  router ready
rtr_ack_out  in  1  router ack_out
rtr_bad_packet  in  1  router bad_packet
receive  out  1  to router receive
header_in  out  6  to router
address_in  out  12  to router
data_in  out  32  to router
level  out  $clog2(DEPTH)+1  FIFO occupancy
sent_count  out  16  packets accepted by the router (ack_out seen)
drop_count  out  16  packets dropped after resend exhaustion or timeout

Behaviour:
- Reset values: all outputs 0 except src_ready=1. FIFO is empty, FSM is in IDLE, counters are 0. Reset mid-send drops the in-flight packet and does not count it.
- Push: src_valid && src_ready writes the entry at the next edge. No same-cycle bypass. A push while full is ignored; src_ready is already 0.
- Pop occurs only as described in the FSM below. Push and pop in the same cycle leaves level unchanged.
- Head entry stays registered on header_in/address_in/data_in whenever the FIFO is non-empty. All router-side outputs are registered.
- FSM states:
  - IDLE: if !empty && rtr_ready && !cfg_busy, go to SEND and set receive=1 on the next cycle.
  - SEND: hold receive=1 and all fields stable until rtr_ready falls (router accepted). Then drop receive to 0, clear the timer, go to WAIT.
    - If cfg_busy rises while in SEND, drop receive and return to IDLE. No pop, no count.
  - WAIT: timer increments each cycle.
    - rtr_ack_out=1: pop, sent_count+1, attempt counter cleared, go to DRAIN.
    - rtr_bad_packet=1 (with no prior ack_out for this packet): if attempts < RESEND_LIMIT, attempts+1 and go to IDLE (resend the same head). Otherwise pop, drop_count+1, go to IDLE.
    - Timer reaches TIMEOUT-1 with neither seen: pop, drop_count+1, go to IDLE.
  - DRAIN: ignore rtr_bad_packet, which comes from a router transmit failure after ack and is not a checksum fault. Wait for rtr_ready=1, then go to IDLE.
- rtr_ack_out and rtr_bad_packet both high in WAIT: ack_out wins.
- Counters saturate at 16'hFFFF and do not wrap.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full = (level==DEPTH), empty = (level==0).

Optional Feature:
ROUTER_INGRESS_HDRGEN_EN:
- Defined: the header stored on push is the popcount of src_data (0..32, 6 bits), computed combinationally at push, and src_header is unused. No checksum rejections are expected from the source.
- Undefined: src_header is stored verbatim.

Decomposition:
- Package router_pkg holds:
  - HDR_W=6, ADDR_W=12, DATA_W=32
  - typedef struct packed pkt_t {header, address, data}
  - typedef enum ingress_state_t {IDLE, SEND, WAIT, DRAIN}
- One sub-module, router_ingress_fifo: a DEPTH-entry pkt_t FIFO with push/pop/level/full/empty. The FSM, counters and popcount live in the top.

Test Plan:
- Push {hdr 32, addr 12'hF0F, data 32'hFFFFFFFF}, rtr_ready=1, router acks 3 cycles after accept -> receive held until ready falls; sent_count=1; level 1->0.
- Push {hdr 13, data 32'h00000FFF}, router asserts bad_packet twice, RESEND_LIMIT=1 -> exactly 2 receive pulses, then pop, drop_count=1, sent_count unchanged. With HDRGEN_EN defined, header_in=12 instead.
- Push 5 packets back-to-back with DEPTH=4 and rtr_ready=0 -> src_ready=0 after the 4th; the 5th is not stored; level=4.
- cfg_busy=1 with a non-empty FIFO and rtr_ready=1 -> receive stays 0. Release cfg_busy -> receive=1 on the next edge.
- After ack_out, router asserts bad_packet (RETRY->ERROR path) -> drop_count stays 0; FSM returns to IDLE on rtr_ready.
- No router response for 16 cycles -> drop_count=1, head popped. Assert reset mid-SEND -> receive=0 and level=0 on the next edge.
